// File: rtl/to_vga.sv
// to_vga: 640x480@60 VGA timing generator with registered, blanked colour output.
module to_vga #(
    parameter int COLOR_W   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COLOR_W-1:0] r,
    input  logic [COLOR_W-1:0] g,
    input  logic [COLOR_W-1:0] b,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] rout,
    output logic [COLOR_W-1:0] gout,
    output logic [COLOR_W-1:0] bout,
    output logic [9:0]         x,
    output logic [9:0]         y,
    output logic               visible
);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] HS_ON  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_OFF = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] VS_ON  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_OFF = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    assign visible = (x < H_VIS) && (y < V_VIS);

    // Sync and colour are registered from the same sample so they stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            x     <= '0;
            y     <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            rout  <= '0;
            gout  <= '0;
            bout  <= '0;
        end else begin
            x     <= (x == H_LAST) ? '0 : x + 10'd1;
            y     <= (x != H_LAST) ? y : (y == V_LAST) ? '0 : y + 10'd1;
            hsync <= !((x >= HS_ON) && (x < HS_OFF));
            vsync <= !((y >= VS_ON) && (y < VS_OFF));
            rout  <= visible ? r : '0;
            gout  <= visible ? g : '0;
            bout  <= visible ? b : '0;
        end
    end
endmodule

// File: tb/tb_to_vga.sv
// tb_to_vga: scoreboard bench; vertical timing shortened (13 lines) to keep frames short.
module tb_to_vga;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] r = '0, g = '0, b = '0;
    logic       hsync, vsync, visible;
    logic [1:0] rout, gout, bout;
    logic [9:0] x, y;

    to_vga #(.V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) dut (
        .clk(clk), .reset(reset), .r(r), .g(g), .b(b),
        .hsync(hsync), .vsync(vsync), .rout(rout), .gout(gout), .bout(bout),
        .x(x), .y(y), .visible(visible)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [9:0] x, y;
        logic       vis, hs, vs;
        logic [1:0] r, g, b;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 20) $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, req);
        end
    endtask

    int hlow = 0, vlow = 0;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("x", 32'(x), 32'(e.x));
            chk("y", 32'(y), 32'(e.y));
            chk("visible", 32'(visible), 32'(e.vis));
            chk("hsync", 32'(hsync), 32'(e.hs));
            chk("vsync", 32'(vsync), 32'(e.vs));
            chk("rout", 32'(rout), 32'(e.r));
            chk("gout", 32'(gout), 32'(e.g));
            chk("bout", 32'(bout), 32'(e.b));
            if (hsync === 1'b0) hlow++;
            else if (hlow != 0) begin chk("hsync_width", 32'(hlow), 32'd96); hlow = 0; end
            if (vsync === 1'b0) vlow++;
            else if (vlow != 0) begin chk("vsync_width", 32'(vlow), 32'd1600); vlow = 0; end
        end
    end

    // Model state: counters and inputs seen during the previous clock
    int mx = 0, my = 0;
    logic p_rst = 1'b1;
    logic [1:0] p_r = '0, p_g = '0, p_b = '0;
    logic ehs = 1'b1, evs = 1'b1;
    logic [1:0] er = '0, eg = '0, eb = '0;

    task automatic cyc(input logic rst, input logic [1:0] rr, input logic [1:0] gg, input logic [1:0] bb);
        exp_t e;
        logic v;
        @(posedge clk);
        #1;
        if (p_rst) begin
            mx = 0; my = 0; ehs = 1'b1; evs = 1'b1; er = '0; eg = '0; eb = '0;
        end else begin
            v   = (mx < 640) && (my < 6);
            er  = v ? p_r : 2'd0;
            eg  = v ? p_g : 2'd0;
            eb  = v ? p_b : 2'd0;
            ehs = !(mx >= 656 && mx <= 751);
            evs = !(my >= 8 && my <= 9);
            if (mx == 799) begin mx = 0; my = (my == 12) ? 0 : my + 1; end
            else mx++;
        end
        e.x = 10'(mx); e.y = 10'(my); e.vis = (mx < 640) && (my < 6);
        e.hs = ehs; e.vs = evs; e.r = er; e.g = eg; e.b = eb;
        q.push_back(e);
        reset = rst; r = rr; g = gg; b = bb;
        p_rst = rst; p_r = rr; p_g = gg; p_b = bb;
    endtask

    initial begin
        logic [1:0] alt;
        logic [9:0] k;
        int n;
        repeat (3) cyc(1'b1, 2'd3, 2'd3, 2'd3);
        alt = 2'd2;
        for (int i = 0; i < 2 * 10400 + 5; i++) begin
            cyc(1'b0, alt, alt, alt);
            alt = (alt == 2'd2) ? 2'd1 : 2'd2;
        end
        n = 0;
        while (!(mx == 299 && my == 3) && n < 11000) begin
            cyc(1'b0, alt, alt, alt);
            alt = (alt == 2'd2) ? 2'd1 : 2'd2;
            n++;
        end
        chk("reach_reset_point", 32'(n < 11000), 32'd1);
        repeat (3) cyc(1'b1, 2'd3, 2'd2, 2'd1);
        k = '0;
        for (int i = 0; i < 10400 + 900; i++) begin
            cyc(1'b0, k[1:0], k[2:1], ~k[1:0]);
            k++;
        end
        n = 0;
        while (q.size() > 0 && n < 10) begin @(negedge clk); n++; end
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
